exact_mult_slot_arbiter: RTL and testbench
==========================================

Name: exact_mult_slot_arbiter

Overview:
Shares one exact signed HALF×HALF multiplier among NUM_REQ approximate-multiplier PEs, such as the PE triplet.
- Replaces the free-running usage counter with a controller.
- Generates the legacy slot count, grants the multiplier in fixed-TDM or round-robin mode, and returns a registered, tagged product.
- Sits beside the PE row in the fast clock domain.

Parameters:
DATA_WIDTH, 8, PE operand width; HALF = DATA_WIDTH/2 is the exact-multiplier operand width
NUM_REQ, 3, number of requesting PEs (legal 2..3)

Ports:
clk  input  1  single clock (PE fast clock)
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = advance slots and issue grants; 0 = freeze
mode  input  1  0 = fixed TDM slots, 1 = work-conserving round-robin
req  input  NUM_REQ  per-PE request, level, held until granted
op_a  input  NUM_REQ*HALF  packed signed high-half operands; PE k at [k*HALF +: HALF]
op_b  input  NUM_REQ*HALF  packed signed high-half operands, same packing
gnt  output  NUM_REQ  one-hot or zero; combinational from registered state and req
rsp_valid  output  1  one-cycle pulse, product valid
rsp_id  output  2  index of the PE owning rsp_product
rsp_product  output  DATA_WIDTH  signed product op_a_k*op_b_k
slot_count  output  2  legacy usage-counter encoding

Behaviour:
Reset values (async, rst_n low):
- slot_count=0, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_product=0, gnt=0.
- Any in-flight product is discarded.

slot_count:
- Advances on each clk rising edge with enable=1: 0 -> 1, then 1 -> 2 -> ... -> NUM_REQ -> 1.
- Never returns to 0 except by reset.
- Holds while enable=0.

TDM mode (mode=0):
- Cycle owner is slot_count-1, using the pre-edge value.
- When slot_count=0, no owner and gnt=0.
- gnt[owner]=req[owner]; other bits 0.
- Slots are never reassigned; an unused slot idles the multiplier.

Round-robin mode (mode=1):
- Grants the first set req at or after index rr_ptr, cyclically.
- On a grant to PE w, rr_ptr <= (w+1) mod NUM_REQ.
- No request leaves rr_ptr unchanged.
- slot_count still advances in this mode.

enable=0: gnt=0; slot_count and rr_ptr hold. The pipeline still drains, so a grant from the previous cycle still produces rsp_valid.

Mode switch: takes effect on the cycle mode is sampled. rr_ptr and slot_count are unaffected.

Handshake:
- Operands of the granted PE are sampled at the clk edge where gnt[w]=1.
- The PE may drop req or change its operands after that edge.
- A req held high through its grant is a new request next cycle (back-to-back grants allowed in RR).

Datapath:
- Latency 1: rsp_valid=1, rsp_id=w, rsp_product=sext(op_a_w)*sext(op_b_w), computed at full DATA_WIDTH precision (no overflow possible), one cycle after the grant.
- When rsp_valid=0, rsp_product and rsp_id hold their last values.
- No backpressure; throughput is 1 product per cycle.

Simultaneous events:
- All req high in TDM: only the owner is granted.
- reset asserted in the same cycle as a grant: reset wins, and no rsp_valid follows.

Optional Feature:
EXACT_MULT_STATS_EN
- Defined: adds output stall_cnt (16 bits). It increments each enabled cycle in which req has any bit set and gnt=0, saturates at 16'hFFFF, and is reset to 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset release, enable=1, req=0 -> slot_count sequence 0,1,2,3,1,2,3; gnt stays 0; rsp_valid stays 0.
2. TDM, req=3'b111; PE0 a=4'h5, b=4'h4; PE1 a=4'hD (-3), b=4'h5; PE2 a=4'h7, b=4'h7 -> gnt 000,001,010,100; then rsp_product 20 (id0), 8'hF1 = -15 (id1), 49 (id2), each one cycle after its grant.
3. RR, only req[2]=1 held, a=4'h8 (-8), b=4'h8 (-8) -> gnt[2] every cycle; rsp_product=64 each cycle after the first; rr_ptr stays 0.
4. RR, req=3'b011 continuous -> grants alternate PE0, PE1, PE0, ...; TDM with req=3'b010 -> grant only when slot_count=2.
5. Grant at cycle n, enable=0 at cycle n+1 -> rsp_valid still 1 at n+1; gnt=0 and slot_count frozen while enable=0.
6. rst_n pulled low the cycle after a grant -> rsp_valid=0 and all outputs 0 immediately. With EXACT_MULT_STATS_EN defined: TDM, req=3'b001 held for 9 enabled cycles from slot_count=1 -> stall_cnt=6.

Source files
------------

// File: rtl/exact_mult_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : exact_mult_slot_arbiter
// Description : Shares one exact signed HALF x HALF multiplier among NUM_REQ
//               approximate-multiplier PEs. It supports two grant modes:
//               fixed TDM slots, or work-conserving round-robin. It also
//               generates the legacy slot count and returns a registered,
//               tagged product one cycle after each grant.
//
// Ports       : clk          PE fast clock
//               rst_n        asynchronous active-low reset
//               enable       1 = advance slots / issue grants, 0 = freeze
//               mode         0 = fixed TDM, 1 = round-robin
//               req          per-PE level request
//               op_a, op_b   packed signed HALF-bit operands, PE k at [k*HALF +: HALF]
//               gnt          one-hot (or zero) grant, combinational
//               rsp_valid    one-cycle product-valid pulse
//               rsp_id       index of the PE owning rsp_product
//               rsp_product  signed DATA_WIDTH-bit product
//               stall_cnt    (EXACT_MULT_STATS_EN only) saturating count of
//                            enabled cycles with a pending request but no grant
//               slot_count   legacy usage-counter encoding
//
// Options     : `define EXACT_MULT_STATS_EN to add the stall_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module exact_mult_slot_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              mode,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*(DATA_WIDTH/2)-1:0] op_a,
    input  logic [NUM_REQ*(DATA_WIDTH/2)-1:0] op_b,
    output logic [NUM_REQ-1:0]                gnt,
    output logic                              rsp_valid,
    output logic [1:0]                        rsp_id,
    output logic [DATA_WIDTH-1:0]             rsp_product,
`ifdef EXACT_MULT_STATS_EN
    output logic [15:0]                       stall_cnt,
`endif
    output logic [1:0]                        slot_count
);

    localparam int         c_half    = DATA_WIDTH / 2;
    localparam logic [1:0] c_num_req = 2'(NUM_REQ);

    logic [1:0]                   r_slot_count;
    logic [1:0]                   r_rr_ptr;
    logic                         r_rsp_valid;
    logic [1:0]                   r_rsp_id;
    logic [DATA_WIDTH-1:0]        r_rsp_product;

    logic [NUM_REQ-1:0]           w_gnt;
    logic [1:0]                   w_gnt_id;
    logic                         w_found;
    logic [c_half-1:0]            w_a;
    logic [c_half-1:0]            w_b;
    logic signed [DATA_WIDTH-1:0] w_a_ext;
    logic signed [DATA_WIDTH-1:0] w_b_ext;
    logic signed [DATA_WIDTH-1:0] w_prod;

    // Cyclic index wrap for values in 0 .. 2*NUM_REQ-1.
    function automatic int f_wrap(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    // Grant selection. In TDM the owner is slot_count-1 (no owner in slot 0).
    // In round-robin the search starts at rr_ptr and wraps around.
    always_comb begin
        w_gnt    = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        if (enable) begin
            if (!mode) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (r_slot_count == 2'(k + 1)) begin
                        w_gnt[k] = req[k];
                        w_gnt_id = 2'(k);
                    end
                end
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!w_found && req[f_wrap(int'(r_rr_ptr) + i)]) begin
                        w_found                             = 1'b1;
                        w_gnt[f_wrap(int'(r_rr_ptr) + i)]   = 1'b1;
                        w_gnt_id                            = 2'(f_wrap(int'(r_rr_ptr) + i));
                    end
                end
            end
        end
    end

    // Operand mux for the granted PE.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_id == 2'(k)) begin
                w_a = op_a[k*c_half +: c_half];
                w_b = op_b[k*c_half +: c_half];
            end
        end
    end

    // Sign-extend to full width first so the product cannot overflow.
    assign w_a_ext = {{(DATA_WIDTH - c_half){w_a[c_half-1]}}, w_a};
    assign w_b_ext = {{(DATA_WIDTH - c_half){w_b[c_half-1]}}, w_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_count  <= '0;
            r_rr_ptr      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
        end else begin
            // Slot 0 is only seen after reset; afterwards cycle 1..NUM_REQ.
            if (enable) begin
                if (r_slot_count == c_num_req) begin
                    r_slot_count <= 2'd1;
                end else begin
                    r_slot_count <= r_slot_count + 2'd1;
                end
            end

            if (enable && mode && (|w_gnt)) begin
                r_rr_ptr <= 2'(f_wrap(int'(w_gnt_id) + 1));
            end

            // Pipeline drains regardless of enable; gnt is already 0 when frozen.
            r_rsp_valid <= |w_gnt;
            if (|w_gnt) begin
                r_rsp_id      <= w_gnt_id;
                r_rsp_product <= w_prod;
            end
        end
    end

`ifdef EXACT_MULT_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (enable && (|req) && !(|w_gnt) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign gnt         = w_gnt;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_rsp_product;
    assign slot_count  = r_slot_count;

endmodule
`default_nettype wire

// File: tb/tb_exact_mult_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_exact_mult_slot_arbiter
// Description : Directed self-checking bench for exact_mult_slot_arbiter
//               (DATA_WIDTH=8, NUM_REQ=3) with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exact_mult_slot_arbiter;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        mode;
    logic [2:0]  req;
    logic [11:0] op_a;
    logic [11:0] op_b;
    logic [2:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_product;
    logic [1:0]  slot_count;
`ifdef EXACT_MULT_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    exact_mult_slot_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (3)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
`ifdef EXACT_MULT_STATS_EN
        .stall_cnt   (stall_cnt),
`endif
        .slot_count  (slot_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: check pre-edge slot/grant and the response from the
    // previous edge (if chk), then advance one clock.
    task automatic cyc(input string tag, input logic [1:0] eslot, input logic [2:0] egnt,
                       input logic chk, input logic ev, input logic [1:0] eid,
                       input logic [7:0] ep);
        #1;
        check({tag, ".slot"}, 32'(slot_count), 32'(eslot));
        check({tag, ".gnt"},  32'(gnt),        32'(egnt));
        if (chk) begin
            check({tag, ".valid"}, 32'(rsp_valid), 32'(ev));
            if (ev) begin
                check({tag, ".id"},   32'(rsp_id),      32'(eid));
                check({tag, ".prod"}, 32'(rsp_product), 32'(ep));
            end
        end
        tick();
    endtask

    initial begin
        logic [1:0] t1_slots [7];
        t1_slots = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};

        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 1'b0;
        req    = '0;
        op_a   = '0;
        op_b   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.slot",  32'(slot_count),  32'd0);
        check("rst.gnt",   32'(gnt),         32'd0);
        check("rst.valid", 32'(rsp_valid),   32'd0);
        check("rst.id",    32'(rsp_id),      32'd0);
        check("rst.prod",  32'(rsp_product), 32'd0);

        // 1: slot sequence, idle
        rst_n  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc("t1", t1_slots[i], 3'b000, 1'b1, 1'b0, 2'd0, 8'h00);
        end

        // 2: TDM, all requesting
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req   = 3'b111;
        op_a  = 12'h7D5;   // PE2=7, PE1=-3, PE0=5
        op_b  = 12'h754;   // PE2=7, PE1=5,  PE0=4
        cyc("t2c0", 2'd0, 3'b000, 1'b1, 1'b0, 2'd0, 8'h00);
        cyc("t2c1", 2'd1, 3'b001, 1'b1, 1'b0, 2'd0, 8'h00);
        cyc("t2c2", 2'd2, 3'b010, 1'b1, 1'b1, 2'd0, 8'h14);
        cyc("t2c3", 2'd3, 3'b100, 1'b1, 1'b1, 2'd1, 8'hF1);
        cyc("t2c4", 2'd1, 3'b001, 1'b1, 1'b1, 2'd2, 8'h31);

        // 3: RR, only PE2 (-8 * -8)
        mode = 1'b1;
        req  = 3'b100;
        op_a = 12'h800;
        op_b = 12'h800;
        cyc("t3a", 2'd2, 3'b100, 1'b0, 1'b0, 2'd0, 8'h00);
        cyc("t3b", 2'd3, 3'b100, 1'b1, 1'b1, 2'd2, 8'h40);
        cyc("t3c", 2'd1, 3'b100, 1'b1, 1'b1, 2'd2, 8'h40);

        // 4: RR alternation (rr_ptr back at 0 -> PE0 first), then TDM req=010
        req  = 3'b011;
        op_a = 12'h832;    // PE1=3, PE0=2
        op_b = 12'h8E6;    // PE1=-2, PE0=6
        cyc("t4d", 2'd2, 3'b001, 1'b1, 1'b1, 2'd2, 8'h40);
        cyc("t4e", 2'd3, 3'b010, 1'b1, 1'b1, 2'd0, 8'h0C);
        cyc("t4f", 2'd1, 3'b001, 1'b1, 1'b1, 2'd1, 8'hFA);
        cyc("t4g", 2'd2, 3'b010, 1'b1, 1'b1, 2'd0, 8'h0C);
        mode = 1'b0;
        req  = 3'b010;
        cyc("t4h", 2'd3, 3'b000, 1'b1, 1'b1, 2'd1, 8'hFA);
        cyc("t4i", 2'd1, 3'b000, 1'b1, 1'b0, 2'd0, 8'h00);
        cyc("t4j", 2'd2, 3'b010, 1'b1, 1'b0, 2'd0, 8'h00);
        cyc("t4k", 2'd3, 3'b000, 1'b1, 1'b1, 2'd1, 8'hFA);

        // 5: grant then freeze
        cyc("t5l", 2'd1, 3'b000, 1'b1, 1'b0, 2'd0, 8'h00);
        cyc("t5m", 2'd2, 3'b010, 1'b1, 1'b0, 2'd0, 8'h00);
        enable = 1'b0;
        cyc("t5n", 2'd3, 3'b000, 1'b1, 1'b1, 2'd1, 8'hFA);
        cyc("t5o", 2'd3, 3'b000, 1'b1, 1'b0, 2'd0, 8'h00);
        cyc("t5p", 2'd3, 3'b000, 1'b1, 1'b0, 2'd0, 8'h00);
        enable = 1'b1;

        // 6: reset right after a grant, then reset against a pending grant
        cyc("t6q", 2'd3, 3'b000, 1'b1, 1'b0, 2'd0, 8'h00);
        cyc("t6r", 2'd1, 3'b000, 1'b1, 1'b0, 2'd0, 8'h00);
        cyc("t6s", 2'd2, 3'b010, 1'b1, 1'b0, 2'd0, 8'h00);
        check("t6.valid_pre", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6rst.valid", 32'(rsp_valid),   32'd0);
        check("t6rst.id",    32'(rsp_id),      32'd0);
        check("t6rst.prod",  32'(rsp_product), 32'd0);
        check("t6rst.slot",  32'(slot_count),  32'd0);
        check("t6rst.gnt",   32'(gnt),         32'd0);
        rst_n = 1'b1;
        cyc("t6t", 2'd0, 3'b000, 1'b1, 1'b0, 2'd0, 8'h00);
        cyc("t6u", 2'd1, 3'b000, 1'b1, 1'b0, 2'd0, 8'h00);
        #1;
        check("t6v.gnt", 32'(gnt), 32'b010);
        rst_n = 1'b0;
        tick();
        check("t6v.valid", 32'(rsp_valid),  32'd0);
        check("t6v.slot",  32'(slot_count), 32'd0);
        rst_n = 1'b1;

`ifdef EXACT_MULT_STATS_EN
        // Stall counter: TDM, req=001 for 9 enabled cycles from slot 1
        req = 3'b000;
        cyc("st0", 2'd0, 3'b000, 1'b1, 1'b0, 2'd0, 8'h00);
        check("stall.init", 32'(stall_cnt), 32'd0);
        req = 3'b001;
        repeat (9) tick();
        req = 3'b000;
        #1;
        check("stall.cnt", 32'(stall_cnt), 32'd6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
